parity_serial_tx: RTL and testbench
===================================

Name: parity_serial_tx

Overview:
Serial parity generator and transmitter, the sending end of the parity-check path. It accepts a DATA_W-bit word over a ready/load handshake and computes an even or odd parity bit. It then shifts the frame out one bit per clock: data bits LSB first, then the parity bit. It also holds the full codeword in parallel, so it can drive the existing 5-bit parity checker directly when DATA_W=4.

Parameters:
DATA_W, 4, data bits per frame; legal range 1 to 31; frame length is DATA_W+1 bits.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
din  input  DATA_W  data word to transmit
odd_sel  input  1  parity mode, sampled at accept: 0 = even parity, 1 = odd parity
load  input  1  request to transmit din
ready  output  1  block idle; load is accepted only when ready=1
sout  output  1  serial output bit
sout_valid  output  1  sout carries a frame bit this cycle
frame_done  output  1  one-cycle pulse on the parity-bit cycle
pword  output  DATA_W+1  last accepted codeword {parity, din}

Behaviour:
- Reset (asynchronous, rst=1):
  - state = IDLE; ready=1, sout=0, sout_valid=0, frame_done=0, pword=0.
  - Shift register and bit counter clear.
- Outputs are Moore, decoded from registers only; there is no combinational path from din, load or odd_sel to any output.
- Parity bit P:
  - Even mode: P = XOR of all din bits.
  - Odd mode: P = inverted XOR of all din bits.
  - Result: the ones-count of {P, din} is even in even mode and odd in odd mode.
- States: IDLE, DATA, PAR.
  - IDLE:
    - ready=1, sout_valid=0, sout=0.
    - load=1 at a rising edge → capture din into the shift register, compute P from the odd_sel value at that edge, load pword <= {P, din}, clear counter, go to DATA.
    - load=0 → stay in IDLE.
  - DATA:
    - ready=0, sout_valid=1, sout = shift register bit 0.
    - Each edge: shift right by one and increment the counter.
    - After DATA_W cycles in DATA, go to PAR.
  - PAR:
    - ready=0, sout_valid=1, sout=P, frame_done=1.
    - Next edge → IDLE.
- Latency, with accept at edge k:
  - Data bit i appears in cycle k+1+i.
  - The parity bit appears in cycle k+1+DATA_W.
  - ready returns to 1 in cycle k+2+DATA_W.
  - Maximum throughput is one frame per DATA_W+2 cycles.
- Busy: load while ready=0 is ignored; there is no queuing and no effect on the frame in flight. din and odd_sel changes mid-frame have no effect.
- pword: updates only on accept and holds its value through the frame and the following idle cycles.
- Reset mid-frame: the frame aborts immediately with all outputs at their reset values. No partial parity bit and no frame_done are emitted. ready=1 after release, and the next load starts a fresh frame.
- Load on the exact edge where rst deasserts is not required to be accepted. Tests must apply load at least one cycle after release.

Test Plan:
1. DATA_W=4, odd_sel=0, din=4'b1011, load for 1 cycle → sout 1,1,0,1 then 1; sout_valid high for 5 cycles; frame_done only on the 5th; pword=5'b11011; ready low for exactly 5 cycles.
2. odd_sel=1, din=4'b0000 → sout 0,0,0,0,1; pword=5'b10000. Repeat with din=4'b1111, odd_sel=0 → parity 0, pword=5'b01111.
3. Hold load=1 continuously with din changing every cycle → frames back-to-back with a 1-cycle idle (ready=1) gap; each frame carries the din present at its accept edge; loads during busy cycles are ignored.
4. Assert rst during the 3rd data bit → sout, sout_valid, frame_done and pword go to 0 immediately without waiting for a clock; no frame_done pulse. After release, load din=4'b0110, odd_sel=1 → complete frame 0,1,1,0,1.
5. Loopback, all 16 din values in both modes, pword driving the 5-bit checker → even-mode codewords always have an even ones-count and odd-mode codewords an odd ones-count. The serial stream reassembled LSB-first equals pword for every frame.
6. Parameter sweep DATA_W=1 and DATA_W=8 → frame length DATA_W+1 and ready-low duration DATA_W+1 cycles; DATA_W=1, din=1, even mode → sout 1,1.

Source files
------------

// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - serial parity generator/transmitter: DATA_W data bits LSB first, then parity
module parity_serial_tx #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              odd_sel,
  input  logic              load,
  output logic              ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              frame_done,
  output logic [DATA_W:0]   pword
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic              par_bit;
  logic              p_next;
  logic              accept;

  assign p_next = (^din) ^ odd_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs depend on state and registers only; load feeds just the accept strobe.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    ready      = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          accept     = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        sout_valid = 1'b1;
        sout       = sreg[0];
        if (cnt == LAST_IDX) begin
          next_state = PAR;
        end
      end
      PAR: begin
        sout_valid = 1'b1;
        sout       = par_bit;
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
      pword   <= '0;
    end else if (accept) begin
      sreg    <= din;
      cnt     <= '0;
      par_bit <= p_next;
      pword   <= {p_next, din};
    end else if (state == DATA) begin
      sreg <= sreg >> 1;
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// tb/tb_parity_serial_tx.sv - self-checking bench for parity_serial_tx with a serial-bit scoreboard
module tb_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din = 4'd0;
  logic       odd_sel = 1'b0;
  logic       load = 1'b0;
  logic       ready, sout, sout_valid, frame_done;
  logic [4:0] pword;

  logic [0:0] din1 = 1'b0;
  logic       odd1 = 1'b0, load1 = 1'b0;
  logic       r1, s1, v1, f1;
  logic [1:0] pw1;

  logic [7:0] din8 = 8'd0;
  logic       odd8 = 1'b0, load8 = 1'b0;
  logic       r8, s8, v8, f8;
  logic [8:0] pw8;

  always #5 clk = ~clk;

  parity_serial_tx #(.DATA_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .odd_sel(odd_sel), .load(load),
    .ready(ready), .sout(sout), .sout_valid(sout_valid), .frame_done(frame_done), .pword(pword)
  );

  parity_serial_tx #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .odd_sel(odd1), .load(load1),
    .ready(r1), .sout(s1), .sout_valid(v1), .frame_done(f1), .pword(pw1)
  );

  parity_serial_tx #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .odd_sel(odd8), .load(load8),
    .ready(r8), .sout(s8), .sout_valid(v8), .frame_done(f8), .pword(pw8)
  );

  int         vectors = 0;
  int         errors = 0;
  bit         sb[$];
  int         mcnt = 0;
  logic [4:0] exp_pword = 5'd0;
  bit         mon_en = 1'b0;
  logic [4:0] rx_acc = 5'd0;
  int         rx_idx = 0;
  logic [4:0] last_rx = 5'd0;
  int         frames_seen = 0;

  // Advance one clock; the bench's own frame model decides acceptance and pushes expected bits.
  task automatic step();
    logic p;
    @(posedge clk);
    if (mcnt != 0) begin
      mcnt--;
    end else if (load) begin
      p = (^din) ^ odd_sel;
      for (int i = 0; i < 4; i++) sb.push_back(din[i]);
      sb.push_back(p);
      exp_pword = {p, din};
      mcnt = 5;
    end
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic odd, output int lowcnt);
    din = d;
    odd_sel = odd;
    load = 1'b1;
    step();
    load = 1'b0;
    lowcnt = 0;
    for (int c = 0; c < 8; c++) begin
      din = 4'($urandom);
      odd_sel = 1'($urandom);
      if (!ready) lowcnt++;
      step();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (ready !== (mcnt == 0)) begin
        errors++;
        $display("FAIL mon_ready: got %b expected %b", ready, (mcnt == 0));
      end
      vectors++;
      if (sout_valid !== (mcnt != 0)) begin
        errors++;
        $display("FAIL mon_sout_valid: got %b expected %b", sout_valid, (mcnt != 0));
      end
      vectors++;
      if (frame_done !== (mcnt == 1)) begin
        errors++;
        $display("FAIL mon_frame_done: got %b expected %b", frame_done, (mcnt == 1));
      end
      vectors++;
      if (pword !== exp_pword) begin
        errors++;
        $display("FAIL mon_pword: got %b expected %b", pword, exp_pword);
      end
      if (mcnt != 0) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mon_sb_empty: got sout %b with no expected bit queued", sout);
        end else begin
          automatic bit b = sb.pop_front();
          if (sout !== b) begin
            errors++;
            $display("FAIL mon_sout: got %b expected %b", sout, b);
          end
        end
        if (rx_idx < 5) rx_acc[rx_idx] = sout;
        rx_idx++;
        if (mcnt == 1) begin
          last_rx = rx_acc;
          rx_idx = 0;
          frames_seen++;
        end
      end else begin
        vectors++;
        if (sout !== 1'b0) begin
          errors++;
          $display("FAIL mon_sout_idle: got %b expected 0", sout);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if ({ready, sout, sout_valid, frame_done, pword} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_state: got r=%b s=%b v=%b fd=%b pw=%b expected r=1 s=0 v=0 fd=0 pw=00000",
               ready, sout, sout_valid, frame_done, pword);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int low;
    int f0;
    f0 = frames_seen;
    send(4'b1011, 1'b0, low);
    vectors++;
    if (low != 5) begin errors++; $display("FAIL basic_ready_low: got %0d cycles expected 5", low); end
    vectors++;
    if (pword !== 5'b11011) begin errors++; $display("FAIL basic_pword: got %b expected 11011", pword); end
    vectors++;
    if (last_rx !== 5'b11011) begin errors++; $display("FAIL basic_stream: got %b expected 11011", last_rx); end
    vectors++;
    if (frames_seen != f0 + 1) begin errors++; $display("FAIL basic_frames: got %0d expected %0d", frames_seen - f0, 1); end
  endtask

  task automatic test_parity_modes();
    int low;
    send(4'b0000, 1'b1, low);
    vectors++;
    if (pword !== 5'b10000) begin errors++; $display("FAIL odd_zero_pword: got %b expected 10000", pword); end
    vectors++;
    if (last_rx !== 5'b10000) begin errors++; $display("FAIL odd_zero_stream: got %b expected 10000", last_rx); end
    send(4'b1111, 1'b0, low);
    vectors++;
    if (pword !== 5'b01111) begin errors++; $display("FAIL even_ones_pword: got %b expected 01111", pword); end
    vectors++;
    if (last_rx !== 5'b01111) begin errors++; $display("FAIL even_ones_stream: got %b expected 01111", last_rx); end
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = frames_seen;
    load = 1'b1;
    for (int c = 0; c < 40; c++) begin
      din = 4'($urandom);
      odd_sel = 1'($urandom);
      step();
    end
    load = 1'b0;
    repeat (8) step();
    vectors++;
    if (frames_seen - f0 != 7) begin errors++; $display("FAIL b2b_frames: got %0d expected 7", frames_seen - f0); end
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d queued bits expected 0", sb.size()); end
  endtask

  task automatic test_reset_midframe();
    int low;
    din = 4'b1011;
    odd_sel = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    vectors++;
    if (sout_valid !== 1'b1) begin errors++; $display("FAIL mid_in_frame: got v=%b expected 1", sout_valid); end
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({ready, sout, sout_valid, frame_done, pword} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL mid_async_clear: got r=%b s=%b v=%b fd=%b pw=%b expected r=1 s=0 v=0 fd=0 pw=00000",
               ready, sout, sout_valid, frame_done, pword);
    end
    sb.delete();
    mcnt = 0;
    exp_pword = 5'd0;
    rx_idx = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (frame_done !== 1'b0 || sout_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_hold: got fd=%b v=%b expected 0 0", frame_done, sout_valid);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    mon_en = 1'b1;
    send(4'b0110, 1'b1, low);
    vectors++;
    if (last_rx !== 5'b10110) begin errors++; $display("FAIL mid_after_stream: got %b expected 10110", last_rx); end
    vectors++;
    if (pword !== 5'b10110) begin errors++; $display("FAIL mid_after_pword: got %b expected 10110", pword); end
  endtask

  task automatic test_loopback();
    int low;
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 16; d++) begin
        send(4'(d), 1'(m), low);
        vectors++;
        if ((^pword) !== 1'(m)) begin
          errors++;
          $display("FAIL loop_parity: d=%0d mode=%0d pword=%b ones-parity %b expected %b", d, m, pword, ^pword, 1'(m));
        end
        vectors++;
        if (last_rx !== pword) begin
          errors++;
          $display("FAIL loop_stream: d=%0d mode=%0d got %b expected %b", d, m, last_rx, pword);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int         low1, low8, n1, n8;
    logic [1:0] bits1;
    logic [8:0] bits8;
    logic [7:0] d8;
    logic       o8;
    d8 = 8'($urandom);
    o8 = 1'($urandom);
    low1 = 0; low8 = 0; n1 = 0; n8 = 0; bits1 = 2'd0; bits8 = 9'd0;
    din1 = 1'b1; odd1 = 1'b0; din8 = d8; odd8 = o8;
    load1 = 1'b1; load8 = 1'b1;
    @(posedge clk);
    #1 load1 = 1'b0;
    load8 = 1'b0;
    din1 = 1'b0;
    din8 = ~d8;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (!r1) low1++;
      if (!r8) low8++;
      if (v1) begin if (n1 < 2) bits1[n1] = s1; n1++; end
      if (v8) begin if (n8 < 9) bits8[n8] = s8; n8++; end
    end
    vectors++;
    if (low1 != 2 || n1 != 2) begin errors++; $display("FAIL w1_len: got low=%0d bits=%0d expected 2 2", low1, n1); end
    vectors++;
    if (bits1 !== 2'b11 || pw1 !== 2'b11) begin errors++; $display("FAIL w1_bits: got stream %b pword %b expected 11 11", bits1, pw1); end
    vectors++;
    if (low8 != 9 || n8 != 9) begin errors++; $display("FAIL w8_len: got low=%0d bits=%0d expected 9 9", low8, n8); end
    vectors++;
    if (bits8 !== {(^d8) ^ o8, d8} || pw8 !== {(^d8) ^ o8, d8}) begin
      errors++;
      $display("FAIL w8_bits: got stream %b pword %b expected %b", bits8, pw8, {(^d8) ^ o8, d8});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_modes();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    test_sweep();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
